seg7_scan_decoder: RTL
======================

# seg7_scan_decoder

Passive readback decoder for the multiplexed, active-low 7-segment display bus. It watches the shared segment lines and active-low digit-enable lines, waits for each digit's drive to settle, and decodes the segment pattern back to a hex nibble. It keeps one register per digit and reports a frame-complete pulse and per-digit pattern errors. It sits beside the display driver in the top level and feeds the score self-check logic and the testbench scoreboard.

## Interface
- NUM_DIGITS, 4: number of multiplexed digits. Legal range 1..8.
- SETTLE_CYCLES, 4: consecutive identical samples required before a capture. Must be ≥1.
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- seg_in  in  8  segment bus, active-low. Bit 7 is dp; bits 6:0 are segments g..a.
- an_in  in  NUM_DIGITS  digit enables, active-low. Exactly one low means a valid select.
- clr  in  1  synchronous clear of the capture state. rst_n has priority over clr.
- digit_out  out  4*NUM_DIGITS  decoded nibbles; digit i occupies bits [4i+3:4i].
- digit_valid  out  NUM_DIGITS  digit i holds a good capture.
- dp_out  out  NUM_DIGITS  captured dp per digit, active-high (1 = dp lit).
- err_out  out  NUM_DIGITS  sticky flag: digit i was captured with an undecodable pattern.
- frame_done  out  1  one-cycle pulse when every digit has been captured since the last pulse or clear.

## Operation
- Input stage: seg_in and an_in are registered every cycle into sample registers. All further logic uses the sampled values.
- Stability counter, width $clog2(SETTLE_CYCLES+1):
  - Set to 1 whenever the sampled {seg, an} differs from the previous sample.
  - Otherwise increments, saturating at SETTLE_CYCLES.
- FSM states:
  - WAIT: a new sample pair with a one-hot-low an goes to SETTLE. Any non-one-hot an (all high = blanking, or several low) stays in WAIT.
  - SETTLE: a change of the sample pair restarts the count. A non-one-hot an returns to WAIT. Count == SETTLE_CYCLES triggers a capture and goes to HOLD.
  - HOLD: no further captures until the sample pair changes. On change, go to SETTLE if an is one-hot-low, else WAIT.
- Capture of digit i (i = index of the low an bit):
  - Decode seg bits 6:0 (active-low patterns): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, B=83, C=C6, E=86, F=8E.
  - These codes are written with bit 7 = 1; decoding ignores bit 7.
  - Digit D is driven with the same pattern as 0, so pattern C0 always decodes to 0.
  - Match: write the nibble, set digit_valid[i], latch dp_out[i] = ~seg[7]. err_out[i] keeps its value.
  - No match: digit_out[i] is unchanged, digit_valid[i] is cleared, err_out[i] is set.
  - Both cases set bit i of the internal capture mask.
- frame_done: asserted for one cycle in the cycle after the capture mask becomes all ones. The mask clears in the same cycle, so the next frame starts empty.
- clr: clears digit_valid, err_out and the capture mask, and forces the FSM to WAIT. digit_out and dp_out keep their values.
- Reset values: digit_out=0, digit_valid=0, dp_out=0, err_out=0, frame_done=0, FSM=WAIT, counter=0, sample registers = all ones (blank bus).

## Timing
- Latency: a stable pair first presented before edge k is sampled at edge k. It is captured at edge k+SETTLE_CYCLES-1. Outputs are visible after edge k+SETTLE_CYCLES. With defaults, that is 4 edges.
- A glitch of fewer than SETTLE_CYCLES samples never causes a capture.
- A pair held indefinitely produces exactly one capture.
- Reset mid-settle aborts the capture, with no partial writes.
- clr in the same cycle as a capture: clr wins, and nothing is written to valid, err or the mask.
- Captures of the same digit repeated within one frame overwrite the data; the mask bit is already set.

## Structure
- Shared package seg7_pkg:
  - the 16 active-low pattern localparams (SEG7_0..SEG7_F, shared with the display encoder);
  - an FSM state enum {WAIT, SETTLE, HOLD}.
- Combinational sub-module seg7_pattern_decode: 7-bit pattern in, 4-bit nibble plus match flag out.
- This block holds the sampling stage, counter, FSM and per-digit registers.

## Test plan
- After reset, drive an=1110 and seg=A4 for 4 cycles. Required: digit_out[3:0]=2 and digit_valid=0001 four edges after the first sample, then exactly one capture.
- Scan digits 0..3 with patterns 99, 80, 8E, C6 (dp low on digit 1), 6-cycle dwell each. Required: digit_out=16'hCF84, dp_out=0010, one frame_done pulse after the digit-3 capture.
- Drive seg=FF on digit 2. Required: err_out[2]=1, digit_valid[2]=0, digit_out[11:8] unchanged. A later good frame leaves err_out[2] set until clr.
- Hold a pattern for 3 cycles, then switch an to 1111. Required: no capture. With an=1100 (two digits low), also no capture.
- Assert rst_n low during SETTLE, and separately assert clr in the capture cycle. Required: all outputs at their reset or cleared values, no capture, and frame_done stays low.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment display path.
// Patterns are active-low with bit 7 (dp) held high (dp off).
package seg7_pkg;

  localparam logic [7:0] SEG7_0 = 8'hC0;
  localparam logic [7:0] SEG7_1 = 8'hF9;
  localparam logic [7:0] SEG7_2 = 8'hA4;
  localparam logic [7:0] SEG7_3 = 8'hB0;
  localparam logic [7:0] SEG7_4 = 8'h99;
  localparam logic [7:0] SEG7_5 = 8'h92;
  localparam logic [7:0] SEG7_6 = 8'h82;
  localparam logic [7:0] SEG7_7 = 8'hF8;
  localparam logic [7:0] SEG7_8 = 8'h80;
  localparam logic [7:0] SEG7_9 = 8'h90;
  localparam logic [7:0] SEG7_A = 8'h88;
  localparam logic [7:0] SEG7_B = 8'h83;
  localparam logic [7:0] SEG7_C = 8'hC6;
  // The display encoder drives D with the same pattern as 0.
  localparam logic [7:0] SEG7_D = 8'hC0;
  localparam logic [7:0] SEG7_E = 8'h86;
  localparam logic [7:0] SEG7_F = 8'h8E;

  typedef enum logic [1:0] {
    WAIT,
    SETTLE,
    HOLD
  } state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Maps an active-low 7-segment pattern (g..a) back to its hex nibble.
// SEG7_D is not listed: its pattern is identical to SEG7_0 and decodes as 0.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       match
);

  // Table lookup; anything not in the table is flagged as a mismatch.
  always_comb begin
    nibble = 4'h0;
    match  = 1'b1;
    case (pattern)
      SEG7_0[6:0]: nibble = 4'h0;
      SEG7_1[6:0]: nibble = 4'h1;
      SEG7_2[6:0]: nibble = 4'h2;
      SEG7_3[6:0]: nibble = 4'h3;
      SEG7_4[6:0]: nibble = 4'h4;
      SEG7_5[6:0]: nibble = 4'h5;
      SEG7_6[6:0]: nibble = 4'h6;
      SEG7_7[6:0]: nibble = 4'h7;
      SEG7_8[6:0]: nibble = 4'h8;
      SEG7_9[6:0]: nibble = 4'h9;
      SEG7_A[6:0]: nibble = 4'hA;
      SEG7_B[6:0]: nibble = 4'hB;
      SEG7_C[6:0]: nibble = 4'hC;
      SEG7_E[6:0]: nibble = 4'hE;
      SEG7_F[6:0]: nibble = 4'hF;
      default:     match  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Passive readback of the multiplexed active-low 7-segment bus: samples the
// bus, waits for each digit's drive to settle, and decodes it per digit.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  input  logic                    clr,
  output logic [4*NUM_DIGITS-1:0] digit_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   dp_out,
  output logic [NUM_DIGITS-1:0]   err_out,
  output logic                    frame_done
);

  localparam int unsigned     CntW   = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(SETTLE_CYCLES);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic [7:0]                 seg_q;
  logic [NUM_DIGITS-1:0]      an_q;
  logic                       changed_q;
  logic [CntW-1:0]            cnt_q;
  state_e                     state_q, state_d;
  logic [NUM_DIGITS-1:0][3:0] digit_q;
  logic [NUM_DIGITS-1:0]      valid_q, dp_q, err_q, mask_q, mask_d;
  logic                       frame_done_q;

  logic       pair_diff;
  logic       an_onehot;
  logic       settled;
  logic       capture;
  logic [3:0] nibble;
  logic       match;

  // Comparing the incoming pair with the current sample is the same as
  // comparing the new sample with the previous one, one register earlier.
  assign pair_diff = ({seg_in, an_in} != {seg_q, an_q});
  assign an_onehot = $onehot(~an_q);
  assign settled   = an_onehot && (cnt_q == CntMax);

  seg7_pattern_decode u_decode (
    .pattern (seg_q[6:0]),
    .nibble  (nibble),
    .match   (match)
  );

  // Sample the bus, flag changes and count how long the sample has been stable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q     <= '1;
      an_q      <= '1;
      changed_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      seg_q     <= seg_in;
      an_q      <= an_in;
      changed_q <= pair_diff;
      if (pair_diff) begin
        cnt_q <= CntOne;
      end else if (cnt_q != CntMax) begin
        cnt_q <= cnt_q + CntOne;
      end
    end
  end

  // Capture decision and next state from the sampled pair.
  always_comb begin
    capture = 1'b0;
    state_d = state_q;
    unique case (state_q)
      WAIT: begin
        if (changed_q && an_onehot) begin
          capture = settled;
          state_d = settled ? HOLD : SETTLE;
        end
      end
      SETTLE: begin
        if (!an_onehot) begin
          state_d = WAIT;
        end else if (settled) begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (changed_q) begin
          capture = settled;
          state_d = !an_onehot ? WAIT : (settled ? HOLD : SETTLE);
        end
      end
      default: state_d = WAIT;
    endcase
  end

  // A full mask is consumed by the frame pulse in the same cycle it is reported.
  always_comb begin
    mask_d = (&mask_q) ? '0 : mask_q;
    if (capture) begin
      mask_d = mask_d | ~an_q;
    end
  end

  // FSM state, per-digit capture registers and the frame pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= WAIT;
      digit_q      <= '0;
      valid_q      <= '0;
      dp_q         <= '0;
      err_q        <= '0;
      mask_q       <= '0;
      frame_done_q <= 1'b0;
    end else if (clr) begin
      state_q      <= WAIT;
      valid_q      <= '0;
      err_q        <= '0;
      mask_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      frame_done_q <= &mask_q;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        if (capture && !an_q[i]) begin
          if (match) begin
            digit_q[i] <= nibble;
            valid_q[i] <= 1'b1;
            dp_q[i]    <= ~seg_q[7];
          end else begin
            valid_q[i] <= 1'b0;
            err_q[i]   <= 1'b1;
          end
        end
      end
    end
  end

  assign digit_out   = digit_q;
  assign digit_valid = valid_q;
  assign dp_out      = dp_q;
  assign err_out     = err_q;
  assign frame_done  = frame_done_q;

endmodule
